// File: rtl/ext_pipe.sv
// Immediate extender with a small output FIFO.
// Each accepted operand is extended according to EOp and stored together with
// an error flag; results leave in acceptance order through a ready/valid port.
module ext_pipe #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            imm,
   input  logic [2:0]                 EOp,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           ext,
   output logic                       out_err,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [OUT_W-1:0] mem_q [DEPTH];
   logic             err_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;

   logic             accept, pop;
   logic [OUT_W-1:0] sext, zext, hi_place, res;
   logic             res_err;

   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Flow control depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   // Head entry is gated so an empty buffer presents zeros.
   assign ext       = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_err   = out_valid ? err_q[rd_ptr_q] : 1'b0;

   assign sext      = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign zext      = {{(OUT_W-IN_W){1'b0}}, imm};
   assign hi_place  = {imm, {(OUT_W-IN_W){1'b0}}};

   // Extension result for the operand currently offered.
   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (EOp)
         3'b000:  res = sext;
         3'b001:  res = zext;
         3'b010:  res = hi_place;
         3'b011:  res = {sext[OUT_W-3:0], 2'b00};
         3'b100:  res = {zext[OUT_W-3:0], 2'b00};
         default: res_err = 1'b1;
      endcase
   end

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (accept && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!accept && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
            err_q[i] <= 1'b0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= res;
            err_q[wr_ptr_q] <= res_err;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe with default parameters.
module tb_ext_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] imm;
   logic [2:0]  EOp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ext;
   logic        out_err;
   logic [1:0]  count;

   int passed = 0;
   int total  = 0;

   ext_pipe #(
      .IN_W  (16),
      .OUT_W (32),
      .DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .EOp       (EOp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext       (ext),
      .out_err   (out_err),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand with out_ready=1 and check it appears one edge later.
   task automatic push_check(input string name, input logic [15:0] v, input logic [2:0] op,
                             input logic [31:0] exp_ext, input logic exp_err);
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      imm       = v;
      EOp       = op;
      tick();
      check({name, "_valid"}, out_valid, 1'b1);
      check({name, "_ext"}, ext, exp_ext);
      check({name, "_err"}, out_err, exp_err);
      check({name, "_count"}, count, 2'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      imm       = 16'h0;
      EOp       = 3'b000;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_ext", ext, 32'h0);
      check("rst_err", out_err, 1'b0);
      check("rst_count", count, 2'd0);
      tick();
      tick();
      check("rst_hold_count", count, 2'd0);

      // Release and offer on the same low phase: first rising edge must accept.
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      imm      = 16'h8001;
      EOp      = 3'b000;
      tick();
      check("first_valid", out_valid, 1'b1);
      check("first_ext", ext, 32'hFFFF_8001);
      check("first_count", count, 2'd1);

      push_check("zext", 16'h8001, 3'b001, 32'h0000_8001, 1'b0);
      push_check("hi", 16'h1234, 3'b010, 32'h1234_0000, 1'b0);
      push_check("sext_sh", 16'hFFFF, 3'b011, 32'hFFFF_FFFC, 1'b0);
      push_check("zext_sh", 16'hFFFF, 3'b100, 32'h0003_FFFC, 1'b0);
      push_check("illegal", 16'h1234, 3'b110, 32'h0, 1'b1);
      push_check("after_ill", 16'h0001, 3'b001, 32'h0000_0001, 1'b0);
      push_check("ill_111", 16'hABCD, 3'b111, 32'h0, 1'b1);

      @(negedge clk);
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 1'b0);
      check("drain_ext", ext, 32'h0);
      check("drain_err", out_err, 1'b0);
      check("drain_count", count, 2'd0);

      // Backpressure: fill, ignore a third offer, then drain in order.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      imm       = 16'h0001;
      EOp       = 3'b001;
      tick();
      check("bp_count1", count, 2'd1);
      @(negedge clk);
      imm = 16'h0002;
      tick();
      check("bp_count2", count, 2'd2);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_head", ext, 32'h1);
      @(negedge clk);
      imm = 16'h0003;
      tick();
      check("bp_ignored_count", count, 2'd2);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_ext", ext, 32'h1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_pop1_count", count, 2'd1);
      check("bp_pop1_ext", ext, 32'h2);
      tick();
      check("bp_pop2_count", count, 2'd0);
      check("bp_pop2_valid", out_valid, 1'b0);

      // Steady stream: occupancy stays at one while pointers wrap.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         imm       = 16'(16'h0010 + i);
         EOp       = 3'b001;
         tick();
         check("stream_count", count, 2'd1);
         check("stream_ext", ext, 64'(32'h10 + i));
      end
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      check("stream_end_count", count, 2'd0);

      // Asynchronous reset with a full buffer.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      imm       = 16'h00AA;
      EOp       = 3'b001;
      tick();
      @(negedge clk);
      imm = 16'h00BB;
      tick();
      check("pre_rst_count", count, 2'd2);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_count", count, 2'd0);
      check("arst_ext", ext, 32'h0);
      check("arst_in_ready", in_ready, 1'b1);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_ext", ext, 32'h0);
      push_check("post_rst_push", 16'h0055, 3'b001, 32'h0000_0055, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      check("post_rst_empty", out_valid, 1'b0);
      check("post_rst_count", count, 2'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
